scan_chain_ctrl: RTL and testbench

//   Sequencer for a serial chain of scan flip-flops with active-low set (D/S/TE/TI cells).
//   - On START: shift a parallel pattern into the chain, run one functional capture clock,

---
 rtl/scan_chain_ctrl.sv | 137 +++++++++++++
 tb/tb_scan_chain_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shift a pattern in, pulse one capture clock, shift the result out.
// Optional SCAN_PRESET_EN adds a one-cycle preset (SET_N low) of every cell before loading.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = $clog2(CHAIN_LEN) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [CHAIN_LEN-1:0] load_data_i,
  input  logic                 so_i,
  output logic                 te_o,
  output logic                 ti_o,
  output logic                 set_n_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CHAIN_LEN-1:0] unload_data_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef SCAN_PRESET_EN
    ST_PRESET,
`endif
    ST_SHIFT_IN,
    ST_CAPTURE,
    ST_SHIFT_OUT,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t                 state_q, state_d;
  logic [CHAIN_LEN-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   te_q, te_d;
  logic                   ti_q, ti_d;
  logic                   set_n_q, set_n_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CHAIN_LEN-1:0]   unload_q, unload_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
`ifdef SCAN_PRESET_EN
          state_d = ST_PRESET;
`else
          state_d = ST_SHIFT_IN;
`endif
          sr_d  = load_data_i;
          cnt_d = '0;
        end
      end
`ifdef SCAN_PRESET_EN
      ST_PRESET: begin
        state_d = ST_SHIFT_IN;
      end
`endif
      ST_SHIFT_IN: begin
        sr_d  = {1'b0, sr_q[CHAIN_LEN-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        cnt_d   = '0;
        state_d = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        // Tail cell emerges first and migrates up, so SR[i] ends holding cell i.
        sr_d  = {sr_q[CHAIN_LEN-2:0], so_i};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so TE/TI/SET_N never glitch.
  always_comb begin
    te_d     = (state_d == ST_SHIFT_IN) || (state_d == ST_SHIFT_OUT);
    ti_d     = (state_d == ST_SHIFT_IN) ? sr_d[0] : 1'b0;
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d   = (state_d == ST_DONE);
    unload_d = (state_d == ST_DONE) ? sr_d : unload_q;
`ifdef SCAN_PRESET_EN
    set_n_d  = (state_d != ST_PRESET);
`else
    set_n_d  = 1'b1;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      te_q     <= 1'b0;
      ti_q     <= 1'b0;
      set_n_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      unload_q <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      te_q     <= te_d;
      ti_q     <= ti_d;
      set_n_q  <= set_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      unload_q <= unload_d;
    end
  end

  assign te_o          = te_q;
  assign ti_o          = ti_q;
  assign set_n_o       = set_n_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign unload_data_o = unload_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with an 8-cell behavioural chain whose functional D is ~Q.
// Builds with or without SCAN_PRESET_EN.
module tb_scan_chain_ctrl;

  localparam int N = 8;
`ifdef SCAN_PRESET_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif
  localparam int LAT = 2*N + 2 + PRE;
  localparam int PER = 2*N + 3 + PRE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] load = 8'h00;
  logic       so;
  logic       te, ti, set_n, busy, done;
  logic [7:0] unload;
  logic [7:0] chain = 8'h00;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {logic [7:0] data; int cyc;} sb_t;
  sb_t sbq[$];

  typedef struct {logic [7:0] load; logic [7:0] exp;} vec_t;
  vec_t tbl[8];

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .start_i(start),
    .load_data_i(load),
    .so_i(so),
    .te_o(te),
    .ti_o(ti),
    .set_n_o(set_n),
    .busy_o(busy),
    .done_o(done),
    .unload_data_o(unload)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain model: chain[k] is cell k, cell 0 fed by TI, cell 7 drives SO.
  assign so = chain[7];
  always @(posedge clk) begin
    if (!set_n)   chain <= 8'hFF;
    else if (te)  chain <= {chain[6:0], ti};
    else          chain <= ~chain;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] bitrev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  logic [7:0] held = 8'h00;
  logic       prev_done = 1'b0;

  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      held      <= 8'h00;
      prev_done <= 1'b0;
    end else begin
      if (done) begin
        check("done_pulse", 32'(prev_done), 32'(0));
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got DONE with unload %0h, expected none at cycle %0d", unload, cyc);
        end else begin
          e = sbq.pop_front();
          check("unload_data", 32'(unload), 32'(e.data));
          check("done_cycle", 32'(cyc), 32'(e.cyc));
        end
        held <= unload;
      end else begin
        check("unload_hold", 32'(unload), 32'(held));
      end
      check("busy_done_excl", 32'(busy & done), 32'(0));
      prev_done <= done;
    end
  end

  task automatic wait_drain();
    for (int n = 0; n < 4*PER && sbq.size() != 0; n++) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sbq.size()), 32'(0));
  endtask

  logic [7:0] pat;

  initial begin
    tbl[0] = '{8'hA5, 8'h5A};
    tbl[1] = '{8'h00, 8'hFF};
    tbl[2] = '{8'hFF, 8'h00};
    tbl[3] = '{8'h01, 8'h7F};
    tbl[4] = '{8'h80, 8'hFE};
    tbl[5] = '{8'h0F, 8'h0F};
    tbl[6] = '{8'h3C, 8'hC3};
    tbl[7] = '{8'h12, 8'hB7};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_te", 32'(te), 32'(0));
    check("rst_ti", 32'(ti), 32'(0));
    check("rst_set_n", 32'(set_n), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_unload", 32'(unload), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // A5: TE/TI during shift-in, chain contents at capture, full result
    pat = 8'hA5;
    load = pat;
    start = 1'b1;
    sbq.push_back('{8'h5A, cyc + LAT});
    for (int i = 0; i <= PRE + N; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) start = 1'b0;
`ifdef SCAN_PRESET_EN
      if (i == 0) begin
        check("preset_set_n", 32'(set_n), 32'(0));
        check("preset_te", 32'(te), 32'(0));
      end
      if (i == 1) begin
        check("preset_released", 32'(set_n), 32'(1));
        check("preset_chain_ones", 32'(chain), 32'(8'hFF));
      end
`else
      if (i == 0) check("set_n_idle_high", 32'(set_n), 32'(1));
`endif
      if (i >= PRE && i < PRE + N) begin
        check("shift_in_te", 32'(te), 32'(1));
        check("shift_in_ti", 32'(ti), 32'(pat[i-PRE]));
      end
      if (i == PRE + N) begin
        check("capture_te", 32'(te), 32'(0));
        check("chain_loaded", 32'(chain), 32'(bitrev(pat)));
      end
    end
    wait_drain();

    // Reset mid shift-in aborts and clears the result register
    load = 8'h3C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_shift_te", 32'(te), 32'(1));
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_te", 32'(te), 32'(0));
    check("abort_ti", 32'(ti), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_unload", 32'(unload), 32'(0));
    check("abort_set_n", 32'(set_n), 32'(1));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_abort", 32'(busy), 32'(0));

    // START re-asserted while busy is ignored
    load = 8'h12;
    start = 1'b1;
    sbq.push_back('{8'hB7, cyc + LAT});
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk);
      #1;
      if (i == 1)  start = 1'b0;
      if (i == 3)  begin start = 1'b1; load = 8'hFF; end
      if (i == 4)  start = 1'b0;
      if (i == 10) begin start = 1'b1; load = 8'h00; end
      if (i == 11) start = 1'b0;
      if (i < LAT) check("busy_held", 32'(busy), 32'(1));
      else         check("busy_at_done", 32'(busy), 32'(0));
    end
    load = 8'h00;
    repeat (PER) @(posedge clk);
    #1;
    wait_drain();

    // START held high: back-to-back sequences from the vector table
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load = tbl[i].load;
      sbq.push_back('{tbl[i].exp, cyc + LAT});
      repeat (PER) @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", 32'(busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
